// File: rtl/arb_fixed_prio.sv
// ============================================================================
// Module   : arb_fixed_prio
// Purpose  : Rotatable fixed-priority arbiter. It produces a combinational
//            one-hot grant and a registered copy with an encoded index.
// Options  : ARB_FP_PRIO_CHK_EN enables a registered check that flags any
//            priority pointer which is not one-hot.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_fixed_prio #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] v_vld,
    input  logic [WIDTH-1:0] v_priority,
    output logic [WIDTH-1:0] v_grant,
    output logic [WIDTH-1:0] grant_q,
    output logic [IDX_W-1:0] grant_idx_q,
    output logic             grant_any_q,
    output logic             prio_err
);

    localparam int DBL_W = IDX_W + 1;

    logic [IDX_W-1:0]   w_start;
    logic [2*WIDTH-1:0] w_dbl;
    logic [2*WIDTH-1:0] w_masked;
    logic [DBL_W-1:0]   w_pos;
    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_grant;

    logic [WIDTH-1:0]   r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_any;

    // The request vector is doubled so that the wrap past bit WIDTH-1 becomes
    // a plain lowest-set-bit search above the start index.
    always_comb begin
        w_start = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v_priority[i]) begin
                w_start = IDX_W'(i);
            end
        end

        w_dbl    = {v_vld, v_vld};
        w_masked = '0;
        for (int j = 0; j < 2 * WIDTH; j++) begin
            if (j >= int'(w_start)) begin
                w_masked[j] = w_dbl[j];
            end
        end

        w_found = 1'b0;
        w_pos   = '0;
        for (int j = 2 * WIDTH - 1; j >= 0; j--) begin
            if (w_masked[j]) begin
                w_found = 1'b1;
                w_pos   = DBL_W'(j);
            end
        end

        if (w_pos >= DBL_W'(WIDTH)) begin
            w_idx = IDX_W'(w_pos - DBL_W'(WIDTH));
        end else begin
            w_idx = IDX_W'(w_pos);
        end

        w_grant = '0;
        if (w_found) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    // w_idx is zero whenever nothing is requested, so it doubles as encode(grant).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_grant_any <= 1'b0;
        end else begin
            r_grant     <= w_grant;
            r_grant_idx <= w_idx;
            r_grant_any <= |v_vld;
        end
    end

`ifdef ARB_FP_PRIO_CHK_EN
    logic r_prio_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_err <= 1'b0;
        end else begin
            r_prio_err <= (v_priority == '0) ||
                          ((v_priority & (v_priority - WIDTH'(1))) != '0);
        end
    end

    assign prio_err = r_prio_err;
`else
    assign prio_err = 1'b0;
`endif

    assign v_grant     = w_grant;
    assign grant_q     = r_grant;
    assign grant_idx_q = r_grant_idx;
    assign grant_any_q = r_grant_any;

endmodule

`default_nettype wire

// File: tb/tb_arb_fixed_prio.sv
// ============================================================================
// Module   : tb_arb_fixed_prio
// Purpose  : Self-checking bench for arb_fixed_prio: directed cases, reset
//            behaviour and randomized traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_fixed_prio;

    localparam int W  = 4;
    localparam int IW = $clog2(W);

    logic          clk;
    logic          rst;
    logic [W-1:0]  v_vld;
    logic [W-1:0]  v_priority;
    logic [W-1:0]  v_grant;
    logic [W-1:0]  grant_q;
    logic [IW-1:0] grant_idx_q;
    logic          grant_any_q;
    logic          prio_err;

    int n_cmp;
    int n_bad;

    arb_fixed_prio #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .v_vld       (v_vld),
        .v_priority  (v_priority),
        .v_grant     (v_grant),
        .grant_q     (grant_q),
        .grant_idx_q (grant_idx_q),
        .grant_any_q (grant_any_q),
        .prio_err    (prio_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the requesters in priority order starting at the pointer.
    function automatic logic [W-1:0] ref_grant(logic [W-1:0] vld, logic [W-1:0] prio);
        int s = 0;
        while (s < W && !prio[s]) s++;
        if (s == W) s = 0;
        for (int k = 0; k < W; k++) begin
            if (vld[(s + k) % W]) return W'(1) << ((s + k) % W);
        end
        return '0;
    endfunction

    function automatic int ref_index(logic [W-1:0] onehot);
        for (int k = 0; k < W; k++) if (onehot[k]) return k;
        return 0;
    endfunction

    function automatic logic ref_err(logic [W-1:0] prio);
`ifdef ARB_FP_PRIO_CHK_EN
        return $countones(prio) != 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input pair, check the combinational grant, then the registered view.
    task automatic step(logic [W-1:0] vld, logic [W-1:0] prio, string tag);
        logic [W-1:0] exp_g;
        v_vld      = vld;
        v_priority = prio;
        exp_g      = ref_grant(vld, prio);
        #1;
        check({tag, ".v_grant"}, 32'(v_grant), 32'(exp_g));
        check({tag, ".onehot0"}, 32'($onehot0(v_grant)), 32'd1);
        check({tag, ".subset"},  32'(v_grant & ~vld), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".grant_q"},     32'(grant_q),     32'(exp_g));
        check({tag, ".grant_idx_q"}, 32'(grant_idx_q), 32'(ref_index(exp_g)));
        check({tag, ".grant_any_q"}, 32'(grant_any_q), 32'(|vld));
        check({tag, ".prio_err"},    32'(prio_err),    32'(ref_err(prio)));
    endtask

    initial begin
        logic [W-1:0] rv;
        logic [W-1:0] rp;

        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        v_vld      = '0;
        v_priority = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.grant_q",     32'(grant_q),     32'd0);
        check("rst.grant_idx_q", 32'(grant_idx_q), 32'd0);
        check("rst.grant_any_q", 32'(grant_any_q), 32'd0);
        check("rst.prio_err",    32'(prio_err),    32'd0);
        rst = 1'b0;

        step(4'b1111, 4'b0001, "t1");
        step(4'b1010, 4'b0001, "t2");
        step(4'b1010, 4'b0100, "t3");
        step(4'b0011, 4'b1000, "t4");
        step(4'b0000, 4'b0100, "t5");
        step(4'b1000, 4'b0010, "t5b");
        step(4'b0101, 4'b0000, "zero_ptr");
        step(4'b1100, 4'b0110, "multi_ptr");

        // Reset mid-operation: registered outputs clear, combinational path keeps tracking.
        step(4'b1110, 4'b0100, "pre_rst");
        rst        = 1'b1;
        v_vld      = 4'b1111;
        v_priority = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t6.v_grant", 32'(v_grant), 32'b0001);
            @(posedge clk);
            #1;
            check("t6.grant_q",     32'(grant_q),     32'd0);
            check("t6.grant_any_q", 32'(grant_any_q), 32'd0);
            check("t6.grant_idx_q", 32'(grant_idx_q), 32'd0);
            check("t6.prio_err",    32'(prio_err),    32'd0);
        end
        rst = 1'b0;
        step(4'b1000, 4'b0001, "post_rst");

        for (int n = 0; n < 1000; n++) begin
            rv = W'($urandom);
            if ($urandom_range(0, 7) == 0) rp = W'($urandom);
            else                           rp = W'(1) << $urandom_range(0, W - 1);
            step(rv, rp, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
